// File: rtl/mine_pkg.sv
// Shared board geometry, derived widths, placer state encoding and cell addressing
// used by the mine placer and the reveal logic.
package mine_pkg;

  localparam int ROWS      = 8;
  localparam int COLS      = 8;
  localparam int NUM_MINES = 10;

  localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

  localparam int ROW_W  = $clog2(ROWS);
  localparam int COL_W  = $clog2(COLS);
  localparam int ADDR_W = $clog2(ROWS * COLS);
  localparam int CNT_W  = $clog2(NUM_MINES + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    GEN   = 3'd2,
    CHECK = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_e;

  function automatic logic [ADDR_W-1:0] addr_of(input logic [ROW_W-1:0] row,
                                                input logic [COL_W-1:0] col);
    return ADDR_W'(int'(row) * COLS + int'(col));
  endfunction

endpackage

// File: rtl/mine_placer_if.sv
// Game-FSM handshake plus mine-flag RAM port of the mine placer.
interface mine_placer_if;
  import mine_pkg::*;

  logic              mine_start;
  logic [ROW_W-1:0]  sel_row;
  logic [COL_W-1:0]  sel_col;
  logic              mine_done;
  logic              busy;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic              mem_rdata;
  logic              mem_wr_en;
  logic              mem_wdata;
  logic [CNT_W-1:0]  mines_placed;

  modport master (
    output mine_start, sel_row, sel_col, mem_rdata,
    input  mine_done, busy, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, mines_placed
  );

  modport slave (
    input  mine_start, sel_row, sel_col, mem_rdata,
    output mine_done, busy, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, mines_placed
  );

endinterface

// File: rtl/mine_lfsr.sv
// Free-running 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1); exposes the low bits of
// the value it will hold after the next clock so the placer can decide one cycle ahead.
module mine_lfsr #(
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int          OUT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  output logic [OUT_W-1:0] nxt_bits
);

  localparam logic [15:0] TAPS = 16'hB400;

  if (SEED == 16'h0000) begin : g_bad_seed
    $error("mine_lfsr: SEED must be nonzero");
  end

  logic [15:0] lfsr;
  logic [15:0] lfsr_nxt;

  assign lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAPS : 16'h0000);
  assign nxt_bits = lfsr_nxt[OUT_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr <= SEED;
    else      lfsr <= lfsr_nxt;
  end

endmodule

// File: rtl/mine_placer.sv
// Clears the mine-flag RAM, then places NUM_MINES mines at pseudo-random cells
// outside the 3x3 block around the player's first-selected cell.
//
//   state | meaning
//   IDLE  | waiting for mine_start, outputs low
//   CLEAR | writing 0 to one cell per cycle, address clr_addr
//   GEN   | candidate from LFSR; read strobe high when it is acceptable
//   CHECK | read data returns; existing mine sends us back to GEN
//   WRITE | write 1 to the candidate, bump mines_placed
//   DONE  | mine_done high until mine_start falls
module mine_placer
  import mine_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEF
) (
  input  logic         clk,
  input  logic         rst,
  mine_placer_if.slave bus
);

  localparam int                CELLS     = ROWS * COLS;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);
  localparam logic [CNT_W-1:0]  MINES_C   = CNT_W'(NUM_MINES);

  if (NUM_MINES > CELLS - 9) begin : g_bad_mine_count
    $error("mine_placer: NUM_MINES exceeds ROWS*COLS-9");
  end

  state_e                  state;
  logic [ADDR_W-1:0]       clr_addr;
  logic [ROW_W+COL_W-1:0]  nxt_bits;
  logic [ROW_W-1:0]        nxt_row;
  logic [COL_W-1:0]        nxt_col;
  logic [ADDR_W-1:0]       nxt_addr;
  logic                    nxt_ok;
  logic [CNT_W-1:0]        placed_inc;

  mine_lfsr #(
    .SEED  (LFSR_SEED),
    .OUT_W (ROW_W + COL_W)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .nxt_bits (nxt_bits)
  );

  function automatic logic cand_ok(input logic [ROW_W-1:0] r, input logic [COL_W-1:0] c,
                                   input logic [ROW_W-1:0] sr, input logic [COL_W-1:0] sc);
    int dr;
    int dc;
    dr = int'(r) - int'(sr);
    dc = int'(c) - int'(sc);
    return (int'(r) < ROWS) && (int'(c) < COLS) &&
           !((dr >= -1) && (dr <= 1) && (dc >= -1) && (dc <= 1));
  endfunction

  // Candidate is judged on the LFSR value that will be live in the GEN cycle, so the
  // registered read strobe lines up with that cycle and read data lands in CHECK.
  assign nxt_row    = nxt_bits[ROW_W-1:0];
  assign nxt_col    = nxt_bits[ROW_W+COL_W-1:ROW_W];
  assign nxt_addr   = addr_of(nxt_row, nxt_col);
  assign nxt_ok     = cand_ok(nxt_row, nxt_col, bus.sel_row, bus.sel_col);
  assign placed_inc = bus.mines_placed + CNT_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      clr_addr         <= '0;
      bus.mine_done    <= 1'b0;
      bus.busy         <= 1'b0;
      bus.mem_addr     <= '0;
      bus.mem_rd_en    <= 1'b0;
      bus.mem_wr_en    <= 1'b0;
      bus.mem_wdata    <= 1'b0;
      bus.mines_placed <= '0;
    end else if (bus.busy && !bus.mine_start) begin
      state            <= IDLE;
      bus.busy         <= 1'b0;
      bus.mem_addr     <= '0;
      bus.mem_rd_en    <= 1'b0;
      bus.mem_wr_en    <= 1'b0;
      bus.mem_wdata    <= 1'b0;
      bus.mines_placed <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.mine_start) begin
            state            <= CLEAR;
            clr_addr         <= '0;
            bus.mines_placed <= '0;
            bus.busy         <= 1'b1;
            bus.mem_wr_en    <= 1'b1;
            bus.mem_wdata    <= 1'b0;
            bus.mem_addr     <= '0;
          end
        end
        CLEAR: begin
          if (clr_addr == LAST_ADDR) begin
            state         <= GEN;
            bus.mem_wr_en <= 1'b0;
            bus.mem_rd_en <= nxt_ok;
            bus.mem_addr  <= nxt_addr;
          end else begin
            clr_addr     <= clr_addr + ADDR_W'(1);
            bus.mem_addr <= clr_addr + ADDR_W'(1);
          end
        end
        GEN: begin
          if (bus.mem_rd_en) begin
            state         <= CHECK;
            bus.mem_rd_en <= 1'b0;
          end else begin
            bus.mem_rd_en <= nxt_ok;
            bus.mem_addr  <= nxt_addr;
          end
        end
        CHECK: begin
          if (bus.mem_rdata) begin
            state         <= GEN;
            bus.mem_rd_en <= nxt_ok;
            bus.mem_addr  <= nxt_addr;
          end else begin
            state         <= WRITE;
            bus.mem_wr_en <= 1'b1;
            bus.mem_wdata <= 1'b1;
          end
        end
        WRITE: begin
          bus.mem_wr_en    <= 1'b0;
          bus.mem_wdata    <= 1'b0;
          bus.mines_placed <= placed_inc;
          if (placed_inc == MINES_C) begin
            state         <= DONE;
            bus.busy      <= 1'b0;
            bus.mine_done <= 1'b1;
            bus.mem_addr  <= '0;
          end else begin
            state         <= GEN;
            bus.mem_rd_en <= nxt_ok;
            bus.mem_addr  <= nxt_addr;
          end
        end
        DONE: begin
          if (!bus.mine_start) begin
            state            <= IDLE;
            bus.mine_done    <= 1'b0;
            bus.mines_placed <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mine_placer.sv
// Self-checking bench for mine_placer: behavioural mine RAM, reference LFSR and a
// queue of expected RAM writes.
module tb_mine_placer;
  import mine_pkg::*;

  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  logic        ram [0:63];
  logic [15:0] m_lfsr;
  logic [6:0]  exp_q [$];

  mine_placer_if bus ();

  mine_placer #(.LFSR_SEED(SEED)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) m_lfsr <= SEED;
    else      m_lfsr <= lfsr_step(m_lfsr);
  end

  function automatic bit in_zone(input int r, input int c, input int sr, input int sc);
    int dr;
    int dc;
    dr = r - sr;
    dc = c - sc;
    return (dr >= -1) && (dr <= 1) && (dc >= -1) && (dc <= 1);
  endfunction

  function automatic logic [14:0] outs();
    return {bus.mine_done, bus.busy, bus.mem_addr, bus.mem_rd_en, bus.mem_wr_en,
            bus.mem_wdata, bus.mines_placed};
  endfunction

  task automatic do_reset();
    bus.mine_start = 1'b0;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Runs one placement from start until mine_done, answering reads from the RAM model.
  task automatic play(input int sr, input int sc, input bit force_hit,
                      output int n_zero, output int n_one, output int cycles,
                      output logic [63:0] lay, output int forced_addr);
    bit         prev_rd;
    bit         forced;
    bit         done;
    int         a;
    int         er;
    int         ec;
    logic [6:0] e;
    n_zero = 0; n_one = 0; cycles = 0; lay = '0; forced_addr = -1;
    prev_rd = 1'b0; forced = 1'b0; done = 1'b0;
    exp_q.delete();
    bus.sel_row    = ROW_W'(sr);
    bus.sel_col    = COL_W'(sc);
    bus.mem_rdata  = 1'b0;
    bus.mine_start = 1'b1;
    for (int i = 0; i < 64; i++) exp_q.push_back({1'b0, 6'(i)});
    while (!done && cycles < 5000) begin
      @(negedge clk);
      cycles++;
      a  = int'(bus.mem_addr);
      er = int'(m_lfsr[2:0]);
      ec = int'(m_lfsr[5:3]);
      checks++;
      if (bus.mem_rd_en && bus.mem_wr_en) begin
        failures++;
        $display("FAIL rd_wr_overlap cycle=%0d rd=%b wr=%b required not both", cycles,
                 bus.mem_rd_en, bus.mem_wr_en);
      end
      if (bus.mem_rd_en) begin
        checks++;
        if (a !== er * 8 + ec || in_zone(er, ec, sr, sc)) begin
          failures++;
          $display("FAIL cand_addr got=%0d required=%0d (zone=%0b)", a, er * 8 + ec,
                   in_zone(er, ec, sr, sc));
        end
        if (force_hit && !forced) begin
          forced      = 1'b1;
          forced_addr = a;
          ram[a]      = 1'b1;
        end
        bus.mem_rdata = ram[a];
        if (!ram[a]) exp_q.push_back({1'b1, 6'(a)});
      end else begin
        if (!prev_rd) bus.mem_rdata = 1'b0;
        if (bus.busy && n_zero == 64 && !prev_rd && !bus.mem_wr_en) begin
          checks++;
          if (!in_zone(er, ec, sr, sc)) begin
            failures++;
            $display("FAIL missed_cand cell=%0d got no read required read", er * 8 + ec);
          end
        end
      end
      prev_rd = bus.mem_rd_en;
      if (bus.mem_wr_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL wr_unexpected got addr=%0d data=%b required no write", a, bus.mem_wdata);
        end else begin
          e = exp_q.pop_front();
          if ({bus.mem_wdata, bus.mem_addr} !== e) begin
            failures++;
            $display("FAIL wr_order got addr=%0d data=%b required addr=%0d data=%b",
                     a, bus.mem_wdata, e[5:0], e[6]);
          end
        end
        if (bus.mem_wdata) begin
          checks++;
          if (bus.mines_placed !== CNT_W'(n_one)) begin
            failures++;
            $display("FAIL placed_count got=%0d required=%0d", bus.mines_placed, n_one);
          end
          n_one++;
          lay[a] = 1'b1;
        end else begin
          n_zero++;
        end
        ram[a] = bus.mem_wdata;
      end
      if (bus.mine_done) done = 1'b1;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL done_timeout got no mine_done after %0d cycles required done", cycles);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL writes_missing got %0d pending required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    bus.mine_start = 1'b0;
    bus.sel_row    = '0;
    bus.sel_col    = '0;
    bus.mem_rdata  = 1'b0;
    #1 rst = 1'b0;
    #2;
    checks++;
    if (outs() !== 15'h0) begin
      failures++;
      $display("FAIL reset_outs got=%h required=0", outs());
    end
    checks++;
    if (dut.u_lfsr.lfsr !== SEED) begin
      failures++;
      $display("FAIL reset_lfsr got=%h required=%h", dut.u_lfsr.lfsr, SEED);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (dut.u_lfsr.lfsr !== lfsr_step(SEED)) begin
      failures++;
      $display("FAIL lfsr_step got=%h required=%h", dut.u_lfsr.lfsr, lfsr_step(SEED));
    end
    checks++;
    if (outs() !== 15'h0) begin
      failures++;
      $display("FAIL idle_outs got=%h required=0", outs());
    end
  endtask

  task automatic test_center_and_hold();
    int nz, no, cyc, fa, bad;
    logic [63:0] lay;
    play(3, 3, 1'b0, nz, no, cyc, lay, fa);
    bad = 0;
    for (int k = 0; k < 64; k++) if (lay[k] && in_zone(k / 8, k % 8, 3, 3)) bad++;
    checks++;
    if (nz !== 64) begin failures++; $display("FAIL center_clears got=%0d required=64", nz); end
    checks++;
    if (no !== 10 || $countones(lay) !== 10) begin
      failures++;
      $display("FAIL center_mines got writes=%0d distinct=%0d required 10", no, $countones(lay));
    end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL center_zone got=%0d required=0", bad); end
    checks++;
    if (bus.mines_placed !== CNT_W'(10)) begin
      failures++;
      $display("FAIL center_placed got=%0d required=10", bus.mines_placed);
    end
    checks++;
    if (cyc < 95) begin failures++; $display("FAIL center_latency got=%0d required>=95", cyc); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.mine_done !== 1'b1 || bus.busy !== 1'b0) begin
        failures++;
        $display("FAIL hold_done got done=%b busy=%b required done=1 busy=0", bus.mine_done, bus.busy);
      end
    end
    bus.mine_start = 1'b0;
    @(negedge clk);
    checks++;
    if (outs() !== 15'h0) begin
      failures++;
      $display("FAIL drop_start got=%h required=0", outs());
    end
  endtask

  task automatic test_corners();
    int nz, no, cyc, fa;
    logic [63:0] lay;
    play(0, 0, 1'b0, nz, no, cyc, lay, fa);
    checks++;
    if ({lay[0], lay[1], lay[8], lay[9]} !== 4'b0 || no !== 10 || $countones(lay) !== 10) begin
      failures++;
      $display("FAIL corner00 got zone=%b mines=%0d required zone=0 mines=10",
               {lay[0], lay[1], lay[8], lay[9]}, no);
    end
    bus.mine_start = 1'b0;
    @(negedge clk);
    play(7, 7, 1'b0, nz, no, cyc, lay, fa);
    checks++;
    if ({lay[54], lay[55], lay[62], lay[63]} !== 4'b0 || no !== 10 || $countones(lay) !== 10) begin
      failures++;
      $display("FAIL corner77 got zone=%b mines=%0d required zone=0 mines=10",
               {lay[54], lay[55], lay[62], lay[63]}, no);
    end
    bus.mine_start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_preload();
    int nz, no, cyc, fa;
    logic [63:0] lay;
    play(4, 4, 1'b1, nz, no, cyc, lay, fa);
    checks++;
    if (fa < 0 || lay[fa] !== 1'b0) begin
      failures++;
      $display("FAIL preload_skip got addr=%0d written=%b required not written", fa,
               (fa < 0) ? 1'b1 : lay[fa]);
    end
    checks++;
    if (no !== 10 || nz !== 64) begin
      failures++;
      $display("FAIL preload_count got ones=%0d zeros=%0d required 10/64", no, nz);
    end
    bus.mine_start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_abort();
    int nz, no, cyc, fa, seen;
    logic [63:0] lay;
    bus.sel_row    = ROW_W'(2);
    bus.sel_col    = COL_W'(5);
    bus.mine_start = 1'b1;
    repeat (30) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1 || bus.mem_wr_en !== 1'b1) begin
      failures++;
      $display("FAIL abort_inclear got busy=%b wr=%b required 1/1", bus.busy, bus.mem_wr_en);
    end
    bus.mine_start = 1'b0;
    @(negedge clk);
    checks++;
    if (outs() !== 15'h0) begin
      failures++;
      $display("FAIL abort_idle got=%h required=0", outs());
    end
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.mine_done) seen++;
    end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL abort_done got=%0d required=0", seen); end
    play(2, 5, 1'b0, nz, no, cyc, lay, fa);
    checks++;
    if (nz !== 64 || no !== 10) begin
      failures++;
      $display("FAIL abort_restart got zeros=%0d ones=%0d required 64/10", nz, no);
    end
    bus.mine_start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int nz, no, cyc, fa;
    logic [63:0] lay_a;
    logic [63:0] lay_b;
    do_reset();
    repeat (7) @(negedge clk);
    play(3, 3, 1'b0, nz, no, cyc, lay_a, fa);
    bus.mine_start = 1'b0;
    @(negedge clk);
    bus.mine_start = 1'b1;
    repeat (75) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL midrun_busy got=%b required=1", bus.busy);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (outs() !== 15'h0) begin
      failures++;
      $display("FAIL async_reset got=%h required=0", outs());
    end
    checks++;
    if (dut.u_lfsr.lfsr !== SEED) begin
      failures++;
      $display("FAIL reseed got=%h required=%h", dut.u_lfsr.lfsr, SEED);
    end
    bus.mine_start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    repeat (7) @(negedge clk);
    play(3, 3, 1'b0, nz, no, cyc, lay_b, fa);
    checks++;
    if (lay_b !== lay_a || no !== 10) begin
      failures++;
      $display("FAIL replay_layout got=%h required=%h", lay_b, lay_a);
    end
    bus.mine_start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_center_and_hold();
    test_corners();
    test_preload();
    test_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mine_placer.md
Name: mine_placer

Overview:
- Sequenced by the top-level game FSM through a level start / level done handshake (mine_start / mine_done). Runs once per game, after the player's first cell selection.
- First clears the board's mine-flag memory. Then places exactly NUM_MINES mines at pseudo-random cells. No mine is placed on the first-selected cell or its 8 neighbours.
- Sole writer of the mine-flag RAM during placement. It owns the RAM port only while busy.

Parameters:
- ROWS, 8, board rows (power of 2 not required)
- COLS, 8, board columns
- NUM_MINES, 10, mines to place; must be <= ROWS*COLS-9 (checked at elaboration)
- LFSR_SEED, 16'hACE1, nonzero reset value of the 16-bit LFSR
- Derived: ROW_W=clog2(ROWS), COL_W=clog2(COLS), ADDR_W=clog2(ROWS*COLS), CNT_W=clog2(NUM_MINES+1)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- mine_start  in  1  level request from game FSM, held high until mine_done is seen
- sel_row  in  ROW_W  row of first-selected cell, stable while mine_start=1
- sel_col  in  COL_W  column of first-selected cell, stable while mine_start=1
- mine_done  out  1  placement complete, held high until mine_start falls
- busy  out  1  high in any state other than IDLE/DONE
- mem_addr  out  ADDR_W  RAM address = row*COLS+col
- mem_rd_en  out  1  read strobe; mem_rdata valid exactly 1 cycle later
- mem_rdata  in  1  mine flag of the addressed cell
- mem_wr_en  out  1  write strobe
- mem_wdata  out  1  flag to write
- mines_placed  out  CNT_W  running count of placed mines

Behaviour:
- Reset (rst=0, async): state=IDLE, LFSR=LFSR_SEED, all outputs 0 (mine_done, busy, mem_*, mines_placed).
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1. Advances every clock from reset, so cells depend on the player's timing. Never all-zero.
- Candidate: cand_row = lfsr[ROW_W-1:0], cand_col = lfsr[ROW_W+COL_W-1:ROW_W], sampled in GEN.
- States:
  - IDLE: outputs 0. When mine_start=1, clear clr_addr and mines_placed, then go to CLEAR.
  - CLEAR: mem_wr_en=1, mem_wdata=0, mem_addr=clr_addr, one cell per cycle. When clr_addr=ROWS*COLS-1 is written, go to GEN. Takes ROWS*COLS cycles.
  - GEN: sample candidate. Reject (stay in GEN) if cand_row>=ROWS, or cand_col>=COLS, or |cand_row-sel_row|<=1 and |cand_col-sel_col|<=1 (signed compare; edge selections clip naturally). Otherwise drive mem_rd_en=1 and the candidate address, and go to CHECK.
  - CHECK: wait one cycle for mem_rdata. If mem_rdata=1, the cell is already a mine: go to GEN. Else go to WRITE.
  - WRITE: mem_wr_en=1, mem_wdata=1, candidate address; mines_placed++. If the new count = NUM_MINES, go to DONE, else go to GEN.
  - DONE: mine_done=1, busy=0. When mine_start=0, go to IDLE; mine_done falls in that same transition, low from the next cycle.
- Abort: if mine_start falls in CLEAR/GEN/CHECK/WRITE, go to IDLE next cycle. mine_done is never asserted. RAM contents are undefined and the next start re-clears.
- mem_rd_en and mem_wr_en are never high in the same cycle. All mem_* are 0 outside CLEAR/GEN/CHECK/WRITE.
- Minimum latency from start to done: ROWS*COLS + 3*NUM_MINES + 1 cycles. There is no upper bound, because rejections are random, but the elaboration check guarantees progress.
- Rising mine_start while in DONE is impossible; start must fall before a new run.
- Asynchronous reset mid-operation: immediate IDLE, outputs 0, LFSR reseeded.

Decomposition:
- Shared package mine_pkg: ROWS, COLS, NUM_MINES, derived widths, the state encoding (IDLE, CLEAR, GEN, CHECK, WRITE, DONE), and an addr_of(row,col) function shared with the reveal logic.
- One sub-module, mine_lfsr: free-running 16-bit LFSR with seed parameter and clk/rst ports.

Test Plan:
- Start with sel=(3,3), 8x8, 10 mines, behavioural RAM -> exactly 64 zero-writes (addr 0..63), then exactly 10 distinct addresses written 1. None in rows 2-4 × cols 2-4. mine_done rises, mines_placed=10.
- Corner sel=(0,0) -> no mine at addrs 0,1,8,9. Placement completes with 10 mines. Repeat with sel=(7,7): no mine at 54,55,62,63.
- Preload a RAM cell to 1 after CLEAR by forcing mem_rdata=1 on the first CHECK -> no write to that address, FSM returns to GEN, total 1-writes still 10.
- Hold mine_start=1 for 5 cycles after done -> mine_done stays 1. Drop start -> mine_done=0 next cycle, busy=0, mem_* all 0.
- Drop mine_start at cycle 30 (mid-CLEAR) -> IDLE next cycle, mine_done never rises. Restart -> full 64-cycle clear again, then normal completion.
- Assert rst=0 asynchronously during GEN -> all outputs 0 before the next clock edge. After release the LFSR equals LFSR_SEED, and the same start timing reproduces an identical mine layout.
